// File: rtl/spi_master_pkg.sv
// Shared definitions for the 4094 SPI master: FSM state codes, default divider
// and a counter-width helper.
package spi_master_pkg;

    localparam int SPI_CLK_DIV_DEF = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT_LO = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_STROBE   = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Bits needed to count n-1 down to 0; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: down-counter that ticks on terminal count every CLK_DIV
// cycles; restart_i holds it at the reload value so a new phase starts aligned.
module spi_tick_gen
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o,
    output logic first_o
);

    localparam int            CW     = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (restart_i || cnt_q == '0) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o  = (cnt_q == '0);
    assign first_o = (cnt_q == RELOAD);

endmodule

// File: rtl/spi_master_4094.sv
// SPI master for a CD4094 shift-register chain: MSB-first frame of up to DATA_W
// bits, strobe pulse after the last bit, read-back of the chain's serial output.
//
//   state     | meaning
//   IDLE      | waiting for start_i; clock and data idle high
//   SHIFT_LO  | spi_clk low, current bit presented on mosi
//   SHIFT_HI  | spi_clk high, miso captured on first cycle
//   STROBE    | latch pulse to the 4094 outputs
//   DONE      | one-cycle done pulse
module spi_master_4094
    import spi_master_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [5:0]        len_i,
    input  logic              miso_i,
    output logic              spi_clk_o,
    output logic              spi_mosi_o,
    output logic              spi_strobe_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] dout_o
);

    localparam int         BW      = cnt_w(DATA_W);
    localparam logic [6:0] LEN_MAX = 7'(DATA_W);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              spi_clk_q, spi_clk_d;
    logic              mosi_q, mosi_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [6:0]        len_eff;
    logic              restart, tick, first;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart),
        .tick_o    (tick),
        .first_o   (first)
    );

    // Zero or oversized lengths fall back to a full-width frame.
    always_comb begin
        len_eff = {1'b0, len_i};
        if (len_i == 6'd0 || {1'b0, len_i} > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        dout_d  = dout_q;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                restart = 1'b1;
                if (start_i) begin
                    state_d = ST_SHIFT_LO;
                    sr_d    = din_i << (LEN_MAX - len_eff);
                    bit_d   = BW'(len_eff - 7'd1);
                    dout_d  = '0;
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (first) begin
                    dout_d = {dout_q[DATA_W-2:0], miso_i};
                end
                if (tick) begin
                    if (bit_q == '0) begin
                        state_d = ST_STROBE;
                    end else begin
                        state_d = ST_SHIFT_LO;
                        bit_d   = bit_q - BW'(1);
                        sr_d    = sr_q << 1;
                    end
                end
            end
            ST_STROBE: begin
                if (tick) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                restart = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                restart = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with state_q.
    always_comb begin
        spi_clk_d = (state_d != ST_SHIFT_LO);
        mosi_d    = 1'b1;
        if (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI) begin
            mosi_d = sr_d[DATA_W-1];
        end
        strobe_d  = (state_d == ST_STROBE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            bit_q     <= '0;
            dout_q    <= '0;
            spi_clk_q <= 1'b1;
            mosi_q    <= 1'b1;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_q     <= bit_d;
            dout_q    <= dout_d;
            spi_clk_q <= spi_clk_d;
            mosi_q    <= mosi_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign spi_clk_o    = spi_clk_q;
    assign spi_mosi_o   = mosi_q;
    assign spi_strobe_o = strobe_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign dout_o       = dout_q;

endmodule

// File: tb/tb_spi_master_4094.sv
// Randomized bench for spi_master_4094 against a behavioural 4094-chain model
// and frame-timing arithmetic.
module tb_spi_master_4094;

    localparam int DW = 32;
    localparam int C  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [DW-1:0] din_i;
    logic [5:0]    len_i;
    logic          miso_i;
    logic          spi_clk_o, spi_mosi_o, spi_strobe_o, busy_o, done_o;
    logic [DW-1:0] dout_o;

    spi_master_4094 #(.DATA_W(DW), .CLK_DIV(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .din_i        (din_i),
        .len_i        (len_i),
        .miso_i       (miso_i),
        .spi_clk_o    (spi_clk_o),
        .spi_mosi_o   (spi_mosi_o),
        .spi_strobe_o (spi_strobe_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .dout_o       (dout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation state maintained by step()
    int            cyc, rises, strobes, dones, done_cyc, unstable;
    logic [DW-1:0] mosi_word, chain, done_dout;
    logic          prev_sclk = 1'b1;
    logic          last_mosi = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle; also models a 4094 chain whose QS' output feeds miso.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (spi_clk_o && !prev_sclk) begin
            rises++;
            mosi_word = {mosi_word[DW-2:0], spi_mosi_o};
            last_mosi = spi_mosi_o;
            chain     = {chain[DW-2:0], spi_mosi_o};
        end
        if (!spi_clk_o && prev_sclk) miso_i = chain[DW-1];
        if (spi_clk_o && prev_sclk && busy_o && !spi_strobe_o && !done_o && spi_mosi_o !== last_mosi)
            unstable++;
        if (spi_strobe_o) strobes++;
        if (done_o) begin
            dones++;
            done_cyc  = cyc;
            done_dout = dout_o;
        end
        prev_sclk = spi_clk_o;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sclk"},   64'(spi_clk_o),    64'd1);
        chk({tag, "_mosi"},   64'(spi_mosi_o),   64'd1);
        chk({tag, "_strobe"}, 64'(spi_strobe_o), 64'd0);
        chk({tag, "_busy"},   64'(busy_o),       64'd0);
        chk({tag, "_done"},   64'(done_o),       64'd0);
    endtask

    task automatic do_frame(input logic [DW-1:0] din, input logic [5:0] len, input logic [DW-1:0] pre,
                            input int poke_cyc, input int abort_cyc);
        int            L;
        logic [DW-1:0] mask;
        int            exp_done;
        L        = (len == 6'd0 || int'(len) > DW) ? DW : int'(len);
        mask     = (L == DW) ? '1 : ((32'd1 << L) - 32'd1);
        exp_done = 1 + 2 * C * L + C;
        chain    = pre << (DW - L);
        miso_i   = chain[DW-1];
        rises = 0; strobes = 0; dones = 0; done_cyc = -1; unstable = 0;
        mosi_word = '0;
        din_i = din; len_i = len; start_i = 1'b1;
        cyc = 0;
        step();
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'd1);
        chk("dout_cleared", 64'(dout_o), 64'd0);
        for (int k = 0; k < 2000 && dones == 0; k++) begin
            start_i = (poke_cyc != 0 && cyc == poke_cyc);
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                reset = 1'b1;
                #1;
                check_reset_outputs("abort");
                step(); step(); step();
                reset = 1'b0;
                step();
                chk("abort_no_done", 64'(dones), 64'd0);
                chk("abort_no_strobe", 64'(strobes), 64'd0);
                return;
            end
            din_i = $urandom;
            len_i = 6'($urandom);
            step();
        end
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("done_count", 64'(dones), 64'd1);
        chk("sclk_rises", 64'(rises), 64'(L));
        chk("mosi_bits", 64'(mosi_word & mask), 64'(din & mask));
        chk("chain_contents", 64'(chain & mask), 64'(din & mask));
        chk("dout_at_done", 64'(done_dout), 64'(pre & mask));
        chk("strobe_cycles", 64'(strobes), 64'(C));
        chk("mosi_stable_hi", 64'(unstable), 64'd0);
        chk("idle_after", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int d1, d2, d3;
        reset = 1'b1; start_i = 1'b0; din_i = '0; len_i = '0; miso_i = 1'b0;
        #1;
        check_reset_outputs("reset");
        chk("reset_dout", 64'(dout_o), 64'd0);
        step(); step();
        reset = 1'b0;
        step(); step();

        do_frame(32'h0000_00A5, 6'd8, $urandom, 0, 0);
        do_frame($urandom, 6'd8, 32'h0000_003C, 0, 0);
        do_frame(32'hFFFF_FFFF, 6'd0, $urandom, 0, 0);
        do_frame($urandom, 6'd40, $urandom, 0, 0);
        do_frame($urandom, 6'd1, $urandom, 0, 0);
        do_frame($urandom, 6'd32, $urandom, 0, 0);
        for (int i = 0; i < 10; i++)
            do_frame($urandom, 6'($urandom_range(0, 63)), $urandom, 0, 0);

        // Start pulse in the middle of an active frame must be ignored.
        do_frame($urandom, 6'd8, $urandom, 10, 0);

        // Reset mid-frame, then a normal frame.
        do_frame($urandom, 6'd8, $urandom, 0, 12);
        do_frame($urandom, 6'd12, $urandom, 0, 0);

        // start held high: back-to-back frames.
        din_i = $urandom; len_i = 6'd8; start_i = 1'b1;
        dones = 0; cyc = 0; d1 = -1; d2 = -1; d3 = -1;
        for (int k = 0; k < 400 && dones < 3; k++) begin
            step();
            if (done_o) begin
                if (dones == 1) d1 = cyc;
                else if (dones == 2) d2 = cyc;
                else if (dones == 3) d3 = cyc;
            end
        end
        start_i = 1'b0;
        chk("b2b_first_done", 64'(d1), 64'(1 + 2 * C * 8 + C));
        chk("b2b_spacing_1", 64'(d2 - d1), 64'(2 * C * 8 + C + 2));
        chk("b2b_spacing_2", 64'(d3 - d2), 64'(2 * C * 8 + C + 2));
        for (int k = 0; k < 200 && busy_o; k++) step();
        chk("b2b_idle", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_4094.md
SPI_MASTER_4094 -- requirements
Module: spi_master_4094

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the maximum frame length in bits.
REQ-002 The module SHALL have parameter CLK_DIV, default 4, giving the SPI half-period in clk cycles (legal range 1..255).
REQ-003 Port clk, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start_i, input, 1 bit: request to transmit a frame, sampled in IDLE only.
REQ-006 Port din_i, input, DATA_W bits: transmit word, right-justified, latched at start.
REQ-007 Port len_i, input, 6 bits: frame length in bits, latched at start; 0 or any value >DATA_W SHALL mean DATA_W.
REQ-008 Port miso_i, input, 1 bit: serial return data from the end of the 4094 chain.
REQ-009 Port spi_clk_o, output, 1 bit: SPI clock, idle high.
REQ-010 Port spi_mosi_o, output, 1 bit: serial data, idle high.
REQ-011 Port spi_strobe_o, output, 1 bit: 4094 strobe, active high.
REQ-012 Port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-013 Port done_o, output, 1 bit: one-cycle pulse at frame end.
REQ-014 Port dout_o, output, DATA_W bits: received bits, right-justified, zero-extended; held until the next start.

Function
REQ-015 The states SHALL be IDLE, SHIFT_LO, SHIFT_HI, STROBE and DONE.
REQ-016 In IDLE with start_i=1, the block SHALL latch din_i and len_i (L), clear dout_o, and enter SHIFT_LO on the next cycle.
REQ-017 start_i SHALL be ignored in every state other than IDLE.
REQ-018 The frame SHALL be MSB-first: bit L-1 of the latched word first, bit 0 last.
REQ-019 In SHIFT_LO, spi_clk_o=0 and spi_mosi_o=current bit, each held for CLK_DIV cycles, after which the state SHALL be SHIFT_HI.
REQ-020 In SHIFT_HI, spi_clk_o=1 for CLK_DIV cycles; mosi SHALL be stable throughout.
REQ-021 On the first cycle of SHIFT_HI, miso_i SHALL be shifted into dout_o at the LSB.
REQ-022 After SHIFT_HI, the block SHALL go to SHIFT_LO if bits remain, else to STROBE.
REQ-023 In STROBE, spi_strobe_o=1 and spi_clk_o=1 for CLK_DIV cycles, then the state SHALL be DONE.
REQ-024 DONE SHALL last one cycle with done_o=1, then the state SHALL be IDLE; start_i SHALL be accepted again in that IDLE cycle.
REQ-025 done_o SHALL be asserted exactly 1+2*CLK_DIV*L+CLK_DIV cycles after the start-accept edge.
REQ-026 The bit counter and divider counter SHALL be sized by $clog2 of DATA_W and CLK_DIV, and SHALL not wrap during a legal frame.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 Reset SHALL force state=IDLE, spi_clk_o=1, spi_mosi_o=1, spi_strobe_o=0, busy_o=0, done_o=0 and dout_o=0 immediately, independent of clk.
REQ-029 Reset mid-frame SHALL abort the frame with no strobe and no done pulse.
REQ-030 After reset deassertion, the first start SHALL behave as a normal frame.

Structure
REQ-031 The state encoding and the default CLK_DIV SHALL live in a shared package spi_master_pkg.
REQ-032 The half-period timing SHALL be a sub-module spi_tick_gen: a counter with a restart input that emits a tick every CLK_DIV cycles.

Verification
REQ-033 With CLK_DIV=2, L=8 and din=0xA5: mosi at the 8 rising edges SHALL be 1,0,1,0,0,1,0,1; strobe SHALL be high for 2 cycles; done SHALL occur at cycle 35.
REQ-034 With miso driven by a model 4094 chain preloaded with 0x3C and L=8: dout_o SHALL equal 0x3C at done.
REQ-035 With len_i=0 and din=0xFFFFFFFF: there SHALL be 32 rising clock edges with mosi=1 at each, and done SHALL occur at cycle 1+128*... i.e. 1+2*2*32+2=131 for CLK_DIV=2.
REQ-036 A start pulse at cycle 10 of an active frame SHALL have no effect, and exactly one done SHALL occur.
REQ-037 Reset asserted at cycle 12 of a frame SHALL immediately give spi_clk_o=1, mosi=1, strobe=0, busy=0, with no done; a following frame SHALL complete normally.
REQ-038 start_i held high continuously SHALL produce back-to-back frames, with done pulses spaced 1+2*CLK_DIV*L+CLK_DIV+1 cycles apart.
